reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised register file for the pipelined datapath, successor to the fixed 8x16 single-write file.
- Generalised width and depth, two write ports (EX-forwarded write and MEM/WB write), optional hardwired-zero register, optional write-through bypass.
- Per-register busy scoreboard so decode can detect RAW hazards.
- Sits between decode (reads, issue) and writeback (writes).

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 3, address width; depth = 2**ADDR_W.
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes, never busy.
- BYPASS, 1, 1 = a read of a register being written this cycle returns the incoming write data.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- rs1  in  ADDR_W  read port 1 address.
- rs2  in  ADDR_W  read port 2 address.
- bus1  out  DATA_W  read port 1 data.
- bus2  out  DATA_W  read port 2 data.
- busy1  out  1  scoreboard busy bit of rs1.
- busy2  out  1  scoreboard busy bit of rs2.
- we0  in  1  write enable, port 0.
- wa0  in  ADDR_W  write address, port 0.
- wd0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (higher priority).
- wa1  in  ADDR_W  write address, port 1.
- wd1  in  DATA_W  write data, port 1.
- issue_en  in  1  an instruction with a destination issues this cycle.
- issue_rd  in  ADDR_W  destination of the issuing instruction.
- clr0  in  1  when we0 is high, also clear busy[wa0].
- clr1  in  1  when we1 is high, also clear busy[wa1].
- any_busy  out  1  OR of all busy bits.

Behaviour:
- Reset:
  - rst_n low asynchronously clears every register and every busy bit.
  - Outputs during and after reset: bus1/bus2 = 0, busy1/busy2 = 0, any_busy = 0.
  - Deassertion is taken at the next clk edge; no write or issue is accepted while rst_n is low.
  - Reset asserted mid-write discards the write.
- Writes (synchronous, rising clk):
  - we0 writes wd0 to rf[wa0]; we1 writes wd1 to rf[wa1].
  - Same address on both ports: port 1 wins.
  - ZERO_REG=1: writes to address 0 are dropped.
- Reads (combinational, zero latency):
  - busN = rf[rsN].
  - ZERO_REG=1 and rsN = 0: busN = 0 regardless of any write.
  - BYPASS=1 and rsN matches an active write address: busN = that write's data (port 1 over port 0), same cycle.
  - BYPASS=0: written data is visible from the cycle after the edge.
- Scoreboard:
  - issue_en sets busy[issue_rd] at the edge.
  - weK && clrK clears busy[waK] at the edge.
  - Set and clear of the same register in the same cycle: set wins (new producer pending).
  - Both write ports clearing the same register: single clear, no error.
  - ZERO_REG=1: issue to register 0 is ignored; busy[0] stays 0.
  - busyN reflects registered state, with no bypass of same-cycle set/clear.
  - Redundant issue to a register already busy leaves it busy.
  - Clear of a register that is not busy has no effect.
- Widths: no arithmetic. Addresses are always in range by construction (depth = 2**ADDR_W).

Test Plan:
- Reset: write 0xBEEF to r3, then pulse rst_n low between edges -> bus1 for rs1=3 reads 0x0000 immediately (asynchronously); busy1 = 0; any_busy = 0.
- Dual-port collision: we0 = we1 = 1, wa0 = wa1 = 5, wd0 = 0x1111, wd1 = 0x2222 -> next cycle rs1=5 reads 0x2222. In the same cycle with BYPASS=1, rs2=5 reads 0x2222 before the edge.
- Zero register: we1 = 1, wa1 = 0, wd1 = 0xFFFF, issue_en = 1, issue_rd = 0 -> bus1 for rs1=0 = 0x0000 in the write cycle and after; busy1 = 0; any_busy = 0.
- Scoreboard race: r4 busy; same cycle issue_en with issue_rd = 4 and we0 = 1, wa0 = 4, clr0 = 1, wd0 = 0x00AA -> r4 = 0x00AA and busy[4] remains 1. Next cycle clear only -> busy[4] = 0 and any_busy = 0.
- Bypass off (BYPASS=0): write 0x1234 to r2 with rs1=2 -> bus1 shows the old value (0x0000) in the write cycle and 0x1234 one cycle later.
- Width (DATA_W=32, ADDR_W=4): write 0xDEADBEEF to r15 -> rs2=15 reads 0xDEADBEEF; the other 15 registers still read 0.

Source files
------------

// File: rtl/reg_file_sb.sv
// Parametrised two-write-port register file with a per-register busy scoreboard.
// Reads are combinational, with an optional same-cycle write bypass and a hardwired-zero r0.
module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic [DATA_W-1:0] bus1,
  output logic [DATA_W-1:0] bus2,
  output logic              busy1,
  output logic              busy2,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              clr0,
  input  logic              clr1,
  output logic              any_busy
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nxt;
  logic              w0_ok;
  logic              w1_ok;
  logic              byp_en;

  function automatic logic is_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  // Port 1 has priority over port 0 both for bypass and for storage.
  function automatic logic [DATA_W-1:0] read_mux(
    input logic [ADDR_W-1:0] ra,
    input logic [DATA_W-1:0] stored,
    input logic              en,
    input logic              v0,
    input logic [ADDR_W-1:0] a0,
    input logic [DATA_W-1:0] d0,
    input logic              v1,
    input logic [ADDR_W-1:0] a1,
    input logic [DATA_W-1:0] d1
  );
    if (is_zero(ra))              return '0;
    if (en && v1 && (a1 == ra))   return d1;
    if (en && v0 && (a0 == ra))   return d0;
    return stored;
  endfunction

  assign w0_ok  = we0 && !is_zero(wa0);
  assign w1_ok  = we1 && !is_zero(wa1);
  // Bypass is suppressed while reset is held so the read buses stay at zero.
  assign byp_en = (BYPASS != 0) && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w1_ok && (wa1 == ADDR_W'(i)))      rf[i] <= wd1;
        else if (w0_ok && (wa0 == ADDR_W'(i))) rf[i] <= wd0;
      end
    end
  end

  // A same-cycle issue overrides a clear: the new producer is still pending.
  always_comb begin
    busy_nxt = busy;
    for (int i = 0; i < DEPTH; i++) begin
      if ((we0 && clr0 && (wa0 == ADDR_W'(i))) || (we1 && clr1 && (wa1 == ADDR_W'(i))))
        busy_nxt[i] = 1'b0;
      if (issue_en && (issue_rd == ADDR_W'(i)))
        busy_nxt[i] = 1'b1;
    end
    if (ZERO_REG != 0) busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

  assign bus1     = read_mux(rs1, rf[rs1], byp_en, w0_ok, wa0, wd0, w1_ok, wa1, wd1);
  assign bus2     = read_mux(rs2, rf[rs2], byp_en, w0_ok, wa0, wd0, w1_ok, wa1, wd1);
  assign busy1    = busy[rs1];
  assign busy2    = busy[rs2];
  assign any_busy = |busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: default, no-bypass and 32x16 instances, checked through an expectation queue.
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the 16-bit/8-entry instances (A: bypass on, B: bypass off)
  logic [2:0]  rs1, rs2, wa0, wa1, issue_rd;
  logic [15:0] wd0, wd1;
  logic        we0, we1, issue_en, clr0, clr1;
  logic [15:0] a_bus1, a_bus2, b_bus1, b_bus2;
  logic        a_busy1, a_busy2, a_any, b_busy1, b_busy2, b_any;

  // Wide instance C
  logic [3:0]  c_rs1, c_rs2, c_wa0, c_wa1, c_issue_rd;
  logic [31:0] c_wd0, c_wd1, c_bus1, c_bus2;
  logic        c_we0, c_we1, c_issue_en, c_clr0, c_clr1, c_busy1, c_busy2, c_any;

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .bus1(a_bus1), .bus2(a_bus2),
    .busy1(a_busy1), .busy2(a_busy2), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .issue_en(issue_en), .issue_rd(issue_rd),
    .clr0(clr0), .clr1(clr1), .any_busy(a_any));

  reg_file_sb #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .rs1(rs1), .rs2(rs2), .bus1(b_bus1), .bus2(b_bus2),
    .busy1(b_busy1), .busy2(b_busy2), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .issue_en(issue_en), .issue_rd(issue_rd),
    .clr0(clr0), .clr1(clr1), .any_busy(b_any));

  reg_file_sb #(.DATA_W(32), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .rs1(c_rs1), .rs2(c_rs2), .bus1(c_bus1), .bus2(c_bus2),
    .busy1(c_busy1), .busy2(c_busy2), .we0(c_we0), .wa0(c_wa0), .wd0(c_wd0),
    .we1(c_we1), .wa1(c_wa1), .wd1(c_wd1), .issue_en(c_issue_en), .issue_rd(c_issue_rd),
    .clr0(c_clr0), .clr1(c_clr1), .any_busy(c_any));

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t q[$];
  event sample_ev;
  int   checks = 0;
  int   errors = 0;

  localparam int A_BUS1 = 0, A_BUS2 = 1, A_BUSY1 = 2, A_BUSY2 = 3, A_ANY = 4,
                 B_BUS1 = 5, B_BUS2 = 6, B_ANY = 7, C_BUS1 = 8, C_BUS2 = 9, C_ANY = 10;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      A_BUS1:  return {16'h0, a_bus1};
      A_BUS2:  return {16'h0, a_bus2};
      A_BUSY1: return {31'h0, a_busy1};
      A_BUSY2: return {31'h0, a_busy2};
      A_ANY:   return {31'h0, a_any};
      B_BUS1:  return {16'h0, b_bus1};
      B_BUS2:  return {16'h0, b_bus2};
      B_ANY:   return {31'h0, b_any};
      C_BUS1:  return c_bus1;
      C_BUS2:  return c_bus2;
      C_ANY:   return {31'h0, c_any};
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  // Monitor: drains every pending expectation whenever the stimulus marks a sample point.
  always @(sample_ev) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      act = actual(e.sel);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", e.name, act, e.exp, $time);
      end
    end
  end

  task automatic expect_val(input string name, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = name; e.sel = sel; e.exp = v;
    q.push_back(e);
  endtask

  task automatic sample();
    -> sample_ev;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ab();
    we0 = 0; wa0 = 0; wd0 = 0; we1 = 0; wa1 = 0; wd1 = 0;
    issue_en = 0; issue_rd = 0; clr0 = 0; clr1 = 0;
  endtask

  task automatic idle_c();
    c_we0 = 0; c_wa0 = 0; c_wd0 = 0; c_we1 = 0; c_wa1 = 0; c_wd1 = 0;
    c_issue_en = 0; c_issue_rd = 0; c_clr0 = 0; c_clr1 = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_ab(); idle_c();
    rs1 = 3; rs2 = 0; c_rs1 = 0; c_rs2 = 0;

    // Held in reset from time zero
    @(negedge clk);
    expect_val("reset_bus1", A_BUS1, 32'h0);
    expect_val("reset_busy1", A_BUSY1, 32'h0);
    expect_val("reset_any", A_ANY, 32'h0);
    expect_val("reset_c_any", C_ANY, 32'h0);
    sample();
    step();
    rst_n = 1;

    // r3 <- 0xBEEF and issue r3; bypass on A only, busy not bypassed
    we0 = 1; wa0 = 3; wd0 = 16'hBEEF; issue_en = 1; issue_rd = 3; rs1 = 3;
    @(negedge clk);
    expect_val("byp_a_bus1", A_BUS1, 32'hBEEF);
    expect_val("nobyp_b_bus1", B_BUS1, 32'h0);
    expect_val("busy_not_bypassed", A_BUSY1, 32'h0);
    sample();
    step(); idle_ab();
    @(negedge clk);
    expect_val("r3_a_after", A_BUS1, 32'hBEEF);
    expect_val("r3_b_after", B_BUS1, 32'hBEEF);
    expect_val("r3_busy", A_BUSY1, 32'h1);
    expect_val("r3_any", A_ANY, 32'h1);
    sample();

    // Asynchronous reset pulse between edges
    step();
    rst_n = 0;
    #1;
    expect_val("async_rst_bus1", A_BUS1, 32'h0);
    expect_val("async_rst_b_bus1", B_BUS1, 32'h0);
    expect_val("async_rst_busy1", A_BUSY1, 32'h0);
    expect_val("async_rst_any", A_ANY, 32'h0);
    sample();
    we1 = 1; wa1 = 3; wd1 = 16'h5555; issue_en = 1; issue_rd = 3;
    #1;
    expect_val("rst_no_bypass", A_BUS1, 32'h0);
    sample();
    step(); idle_ab();
    rst_n = 1;
    @(negedge clk);
    expect_val("rst_write_dropped", A_BUS1, 32'h0);
    expect_val("rst_issue_dropped", A_ANY, 32'h0);
    sample();

    // Dual-port collision on r5: port 1 wins
    step();
    we0 = 1; wa0 = 5; wd0 = 16'h1111; we1 = 1; wa1 = 5; wd1 = 16'h2222; rs1 = 5; rs2 = 5;
    @(negedge clk);
    expect_val("coll_byp_a_bus2", A_BUS2, 32'h2222);
    expect_val("coll_nobyp_b_bus2", B_BUS2, 32'h0);
    sample();
    step(); idle_ab();
    @(negedge clk);
    expect_val("coll_a_bus1", A_BUS1, 32'h2222);
    expect_val("coll_b_bus1", B_BUS1, 32'h2222);
    sample();

    // Bypass-off read timing on r2
    step();
    we0 = 1; wa0 = 2; wd0 = 16'h1234; rs1 = 2;
    @(negedge clk);
    expect_val("r2_b_old", B_BUS1, 32'h0);
    expect_val("r2_a_byp", A_BUS1, 32'h1234);
    sample();
    step(); idle_ab();
    @(negedge clk);
    expect_val("r2_b_new", B_BUS1, 32'h1234);
    sample();

    // Zero register: write and issue to r0 are ignored
    step();
    we1 = 1; wa1 = 0; wd1 = 16'hFFFF; issue_en = 1; issue_rd = 0; rs1 = 0;
    @(negedge clk);
    expect_val("r0_write_cycle", A_BUS1, 32'h0);
    expect_val("r0_b_write_cycle", B_BUS1, 32'h0);
    sample();
    step(); idle_ab();
    @(negedge clk);
    expect_val("r0_after", A_BUS1, 32'h0);
    expect_val("r0_busy", A_BUSY1, 32'h0);
    expect_val("r0_any", A_ANY, 32'h0);
    sample();

    // Scoreboard race on r4: set beats clear
    step();
    issue_en = 1; issue_rd = 4; rs1 = 4;
    step(); idle_ab();
    issue_en = 1; issue_rd = 4; we0 = 1; wa0 = 4; wd0 = 16'h00AA; clr0 = 1;
    @(negedge clk);
    expect_val("r4_busy_before", A_BUSY1, 32'h1);
    sample();
    step(); idle_ab();
    @(negedge clk);
    expect_val("r4_data", A_BUS1, 32'h00AA);
    expect_val("r4_still_busy", A_BUSY1, 32'h1);
    sample();
    step();
    we0 = 1; wa0 = 4; wd0 = 16'h00AA; clr0 = 1;
    step(); idle_ab();
    @(negedge clk);
    expect_val("r4_cleared", A_BUSY1, 32'h0);
    expect_val("r4_any_clear", A_ANY, 32'h0);
    sample();

    // Redundant issue, write without clr, then dual clear of the same register
    step();
    issue_en = 1; issue_rd = 1; rs1 = 1; rs2 = 7;
    step();
    issue_en = 1; issue_rd = 7;
    step(); idle_ab();
    issue_en = 1; issue_rd = 1;
    we0 = 1; wa0 = 1; wd0 = 16'h0101;
    step(); idle_ab();
    @(negedge clk);
    expect_val("r1_redundant_busy", A_BUSY1, 32'h1);
    expect_val("r7_busy", A_BUSY2, 32'h1);
    expect_val("r1_written_no_clr", A_BUS1, 32'h0101);
    sample();
    step();
    we0 = 1; wa0 = 7; wd0 = 16'h7070; clr0 = 1;
    we1 = 1; wa1 = 7; wd1 = 16'h0707; clr1 = 1;
    step(); idle_ab();
    @(negedge clk);
    expect_val("r7_dual_clear", A_BUSY2, 32'h0);
    expect_val("r7_data_port1", A_BUS2, 32'h0707);
    expect_val("r1_still_busy", A_BUSY1, 32'h1);
    expect_val("any_r1", A_ANY, 32'h1);
    sample();
    step();
    we1 = 1; wa1 = 1; wd1 = 16'h0101; clr1 = 1;
    step(); idle_ab();
    @(negedge clk);
    expect_val("r1_cleared_any", A_ANY, 32'h0);
    expect_val("b_any_clear", B_ANY, 32'h0);
    sample();

    // Wide instance: r15 <- 0xDEADBEEF, others remain zero
    step();
    c_we1 = 1; c_wa1 = 15; c_wd1 = 32'hDEADBEEF;
    step(); idle_c();
    c_rs2 = 15;
    @(negedge clk);
    expect_val("c_r15", C_BUS2, 32'hDEADBEEF);
    sample();
    for (int i = 0; i < 15; i++) begin
      c_rs1 = 4'(i);
      #1;
      expect_val($sformatf("c_r%0d_zero", i), C_BUS1, 32'h0);
      sample();
    end

    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
